// File: rtl/line_buf_reader.sv
// line_buf_reader: pulls one line of pixels from a line FIFO in step with downstream vs/hs/de timing
// Ports: rd_clk/rd_rst clock and sync active-high reset; vs_in/hs_in/de_in downstream timing;
// fifo_rd_en/fifo_rd_data/fifo_rd_empty line FIFO read side; vs_out/hs_out/de_out/pix_out timing and
// pixel delayed 2 cycles; frame_start/line_err status pulses; underflow_cnt/line_cnt per-frame counters.
module line_buf_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE = 1280,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  vs_in,
  input  logic                  hs_in,
  input  logic                  de_in,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  vs_out,
  output logic                  hs_out,
  output logic                  de_out,
  output logic [DATA_WIDTH-1:0] pix_out,
  output logic                  frame_start,
  output logic                  line_err,
  output logic [15:0]           underflow_cnt,
  output logic [11:0]           line_cnt
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t r_state, w_state_nx;
  logic [1:0] r_vs, r_hs, r_de;
  logic [11:0] r_pix_cnt, w_cnt;
  logic r_rd, w_vs_rise, w_de_fall, w_uf;
  assign w_vs_rise = vs_in & ~r_vs[0];
  assign w_de_fall = r_de[0] & ~de_in;
  // a de cycle coinciding with a vs rise is pixel 1 of the new frame, so it sees a cleared count
  assign w_cnt = w_vs_rise ? '0 : r_pix_cnt;
  always_comb begin
    w_state_nx = w_vs_rise ? ACTIVE : r_state;
    w_uf = (r_state == ACTIVE) & de_in & fifo_rd_empty;
    fifo_rd_en = ~rd_rst & (r_state == ACTIVE) & de_in & ~fifo_rd_empty & (w_cnt < 12'(H_ACTIVE));
  end
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state <= IDLE;
      r_vs <= '0;
      r_hs <= '0;
      r_de <= '0;
      r_rd <= 1'b0;
      r_pix_cnt <= '0;
      pix_out <= FILL_VALUE;
      frame_start <= 1'b0;
      line_err <= 1'b0;
      underflow_cnt <= '0;
      line_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_vs <= {r_vs[0], vs_in};
      r_hs <= {r_hs[0], hs_in};
      r_de <= {r_de[0], de_in};
      r_rd <= fifo_rd_en;
      pix_out <= r_rd ? fifo_rd_data : FILL_VALUE;
      frame_start <= w_vs_rise;
      line_err <= w_de_fall & (r_pix_cnt != 12'(H_ACTIVE));
      r_pix_cnt <= w_vs_rise ? {11'b0, de_in} :
                   w_de_fall ? '0 :
                   (de_in && r_pix_cnt != 12'hFFF) ? r_pix_cnt + 12'd1 : r_pix_cnt;
      line_cnt <= w_vs_rise ? '0 : line_cnt + 12'(w_de_fall);
      underflow_cnt <= w_vs_rise ? {15'b0, w_uf} :
                       (w_uf && underflow_cnt != 16'hFFFF) ? underflow_cnt + 16'd1 : underflow_cnt;
    end
  end
  assign vs_out = r_vs[1];
  assign hs_out = r_hs[1];
  assign de_out = r_de[1];
endmodule
